// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus of the link deserializer.
// The master modport is the deserializer; the slave modport is the stream source and word consumer.
interface deserializer_if #(
    parameter int REG_SIZE = 32
);
    logic                      data_in;
    logic                      shift_en;
    logic [REG_SIZE-1:0]       data_out;
    logic                      data_valid;
    logic                      data_ready;
    logic                      frame_done;
    logic                      overrun;
    logic [$clog2(REG_SIZE):0] bit_cnt;

    modport master (
        input  data_in, shift_en, data_ready,
        output data_out, data_valid, frame_done, overrun, bit_cnt
    );

    modport slave (
        output data_in, shift_en, data_ready,
        input  data_out, data_valid, frame_done, overrun, bit_cnt
    );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel receiver with a double-buffered output word.
// It drops new words and raises a sticky overrun when the consumer stalls.
module deserializer #(
    parameter int REG_SIZE  = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    deserializer_if.master bus
);
    localparam int CW = $clog2(REG_SIZE) + 1;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t              state, state_nxt;
    logic [REG_SIZE-1:0] sreg, shifted;
    logic [CW-1:0]       bit_cnt;
    logic                complete;
    logic                load, drop;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sreg[REG_SIZE-2:0], bus.data_in};
        end else begin : g_lsb
            assign shifted = {bus.data_in, sreg[REG_SIZE-1:1]};
        end
    endgenerate

    // The last bit of a word is folded in through the shifted value, not through sreg.
    assign complete = bus.shift_en && (bit_cnt == CW'(REG_SIZE - 1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    load      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (complete) begin
                    if (bus.data_ready) load = 1'b1;
                    else                drop = 1'b1;
                end else if (bus.data_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     state <= EMPTY;
        else if (clear) state <= EMPTY;
        else            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg         <= '0;
            bit_cnt      <= '0;
            bus.data_out <= '0;
            bus.frame_done <= 1'b0;
            bus.overrun  <= 1'b0;
        end else if (clear) begin
            // The held word stays visible; only the valid flag drops.
            sreg         <= '0;
            bit_cnt      <= '0;
            bus.frame_done <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            if (bus.shift_en) begin
                sreg    <= shifted;
                bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
            end
            if (load) bus.data_out <= shifted;
            if (drop) bus.overrun  <= 1'b1;
            bus.frame_done <= complete;
        end
    end

    assign bus.data_valid = (state == HOLD);
    assign bus.bit_cnt    = bit_cnt;
endmodule

// File: tb/tb_deserializer.sv
// Checks MSB-first and LSB-first deserializers against a word-level model.
// The model uses a bit queue and an occupancy flag.
module tb_deserializer;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n, clr, din, sen, rdy;
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    bit         q[$];
    bit         m_full, m_ovr, m_fd;
    logic [7:0] m_wm, m_wl;

    always #5 clk = ~clk;

    deserializer_if #(.REG_SIZE(N)) bm ();
    deserializer_if #(.REG_SIZE(N)) bl ();

    assign bm.data_in = din;  assign bm.shift_en = sen;  assign bm.data_ready = rdy;
    assign bl.data_in = din;  assign bl.shift_en = sen;  assign bl.data_ready = rdy;

    deserializer #(.REG_SIZE(N), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(rst_n), .clear(clr), .bus(bm.master));
    deserializer #(.REG_SIZE(N), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(rst_n), .clear(clr), .bus(bl.master));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_full = 0; m_ovr = 0; m_fd = 0; m_wm = '0; m_wl = '0;
    endtask

    // Apply one clock edge's worth of rules to the model.
    task automatic model_step();
        bit comp;
        comp = 0;
        if (clr) begin
            q.delete();
            m_full = 0; m_ovr = 0; m_fd = 0;
        end else begin
            if (sen) begin
                q.push_back(din);
                if (q.size() == N) comp = 1;
            end
            m_fd = comp;
            if (comp) begin
                if (!m_full || rdy) begin
                    m_full = 1;
                    m_wm = '0; m_wl = '0;
                    for (int i = 0; i < N; i++) begin
                        m_wm = m_wm | (8'(q[i]) << (N - 1 - i));
                        m_wl = m_wl | (8'(q[i]) << i);
                    end
                end else begin
                    m_ovr = 1;
                end
                q.delete();
            end else if (m_full && rdy) begin
                m_full = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("msb_data_out", 32'(bm.data_out), 32'(m_wm));
        chk("lsb_data_out", 32'(bl.data_out), 32'(m_wl));
        chk("data_valid",   32'(bm.data_valid), 32'(m_full));
        chk("lsb_valid",    32'(bl.data_valid), 32'(m_full));
        chk("frame_done",   32'(bm.frame_done), 32'(m_fd));
        chk("overrun",      32'(bm.overrun), 32'(m_ovr));
        chk("bit_cnt",      32'(bm.bit_cnt), 32'(q.size()));
        chk("lsb_bit_cnt",  32'(bl.bit_cnt), 32'(q.size()));
    endtask

    task automatic cycle(input logic d, input logic s, input logic r, input logic c);
        din = d; sen = s; rdy = r; clr = c;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    // Send a word MSB-first on the wire; ready on the last bit may differ.
    task automatic send(input logic [7:0] w, input int gap, input logic r, input logic r_last);
        for (int i = N - 1; i >= 0; i--) begin
            cycle(w[i], 1'b1, (i == 0) ? r_last : r, 1'b0);
            if (i != 0)
                for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, r, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; din = 1'b0; sen = 1'b0; rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        rst_n = 1'b1;

        // A5 with consumer ready
        send(8'hA5, 0, 1'b1, 1'b1);
        chk("a5_word", 32'(bm.data_out), 32'h0A5);
        chk("a5_fd",   32'(bm.frame_done), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_valid_drop", 32'(bm.data_valid), 32'h0);

        // Bit-order distinction
        send(8'hC0, 0, 1'b1, 1'b1);
        chk("c0_msb", 32'(bm.data_out), 32'h0C0);
        chk("c0_lsb", 32'(bl.data_out), 32'h003);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped bits
        send(8'h3C, 3, 1'b1, 1'b1);
        chk("3c_word", 32'(bm.data_out), 32'h03C);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun with stalled consumer
        send(8'h11, 0, 1'b0, 1'b0);
        send(8'h22, 0, 1'b0, 1'b0);
        chk("ovr_word", 32'(bm.data_out), 32'h011);
        chk("ovr_flag", 32'(bm.overrun), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_sticky", 32'(bm.overrun), 32'h1);
        chk("ovr_drain",  32'(bm.data_valid), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clear", 32'(bm.overrun), 32'h0);

        // Ready exactly on the completing bit: replace without a bubble
        send(8'h11, 0, 1'b0, 1'b0);
        send(8'h22, 0, 1'b0, 1'b1);
        chk("swap_word",  32'(bm.data_out), 32'h022);
        chk("swap_valid", 32'(bm.data_valid), 32'h1);
        chk("swap_ovr",   32'(bm.overrun), 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Async reset mid-word
        for (int i = 0; i < 5; i++) cycle(1'(i & 1), 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_data_out", 32'(bm.data_out), 32'h0);
        #1 rst_n = 1'b1;
        send(8'h5A, 0, 1'b1, 1'b1);
        chk("5a_word", 32'(bm.data_out), 32'h05A);
        chk("5a_lsb",  32'(bl.data_out), 32'h05A);

        // Random traffic
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
